// File: rtl/dig_ct_driver.sv
// Stimulus driver and response checker for the 5-in/3-out registered logic cell.
// Drives a counter or LFSR vector stream and scores the cell against a golden model.
module dig_ct_driver #(
   parameter int         NUM_VEC = 32,
   parameter int         MODE    = 0,
   parameter logic [4:0] SEED    = 5'b00001
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       RSP1,
   input  logic       RSP2,
   input  logic       RSP3,
   output logic       IN1,
   output logic       IN2,
   output logic       IN3,
   output logic       IN4,
   output logic       IN5,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] ERR_CNT,
   output logic [4:0] FIRST_ERR_VEC,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [9:0] LAST_IDX = 10'(NUM_VEC);

   state_t     state;
   state_t     state_nxt;
   logic [9:0] idx;
   logic [4:0] vec;
   logic [4:0] vec_first;
   logic [4:0] vec_next;
   logic [2:0] gold;
   logic [2:0] pipe_gold;
   logic [4:0] pipe_vec;
   logic       pipe_vld;
   logic       err_seen;
   logic       start_ok;
   logic       mismatch;

   assign start_ok = START && ((state == S_IDLE) || (state == S_DONE));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (START) state_nxt = S_DRIVE;
         S_DRIVE: if (idx == LAST_IDX) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_DONE;
         S_DONE:  if (START) state_nxt = S_DRIVE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // idx counts vectors already driven, so idx also names the next vector
   always_comb begin
      vec_first = 5'd0;
      vec_next  = idx[4:0];
      if (MODE == 1) begin
         vec_first = SEED;
         vec_next  = {vec[3:0], vec[4] ^ vec[2]};
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         idx <= 10'd0;
         vec <= 5'd0;
      end else if (start_ok) begin
         idx <= 10'd1;
         vec <= vec_first;
      end else if (state == S_DRIVE) begin
         if (idx == LAST_IDX) begin
            vec <= 5'd0;
         end else begin
            idx <= idx + 10'd1;
            vec <= vec_next;
         end
      end
   end

   assign gold = {~(~(vec[0] | vec[1]) & vec[2]),
                  ~(vec[1] & vec[2]),
                  vec[2] | ~vec[3] | vec[4]};

   // One stage matching the cell's own output register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pipe_vld  <= 1'b0;
         pipe_gold <= 3'd0;
         pipe_vec  <= 5'd0;
      end else begin
         pipe_vld  <= (state == S_DRIVE);
         pipe_gold <= gold;
         pipe_vec  <= vec;
      end
   end

   assign mismatch = pipe_vld && ({RSP1, RSP2, RSP3} != pipe_gold);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ERR_CNT       <= 8'd0;
         FIRST_ERR_VEC <= 5'd0;
         err_seen      <= 1'b0;
      end else if (start_ok) begin
         ERR_CNT       <= 8'd0;
         FIRST_ERR_VEC <= 5'd0;
         err_seen      <= 1'b0;
      end else if (mismatch) begin
         if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
         if (!err_seen) begin
            FIRST_ERR_VEC <= pipe_vec;
            err_seen      <= 1'b1;
         end
      end
   end

   assign {IN5, IN4, IN3, IN2, IN1} = vec;
   assign BUSY      = (state == S_DRIVE) || (state == S_DRAIN);
   assign DONE      = (state == S_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_dig_ct_driver.sv
// Bench for dig_ct_driver: three configurations run side by side against a
// cell model with selectable faults, scored by a run-position reference model.
module tb_dig_ct_driver;

   logic CLK;
   logic RST;
   logic START;
   int   fault_mode;
   int   n_checks;
   int   n_fail;

   logic       busy_a [3];
   logic       done_a [3];
   logic [7:0] err_a  [3];
   logic [4:0] first_a[3];
   logic [4:0] in_a   [3];

   int          done_at [3];
   int          busy_cnt[3];
   logic [31:0] seen_mask;
   logic [4:0]  vec1_seen;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [2:0] golden(input logic [4:0] v);
      return {~(~(v[0] | v[1]) & v[2]), ~(v[1] & v[2]), v[2] | ~v[3] | v[4]};
   endfunction

   // Vector j of a run, straight from the source definition
   function automatic logic [4:0] vec_of(input int mode, input logic [4:0] seed, input int j);
      logic [4:0] v;
      if (mode == 0) return 5'(j % 32);
      v = seed;
      for (int i = 0; i < j % 31; i++) v = {v[3:0], v[4] ^ v[2]};
      return v;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int         N  = (g == 0) ? 32 : (g == 1) ? 31 : 300;
      localparam int         MD = (g == 1) ? 1 : 0;
      localparam logic [4:0] SD = 5'b00001;

      logic       i1, i2, i3, i4, i5, busy, done;
      logic       r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
      logic [7:0] err;
      logic [4:0] first;
      logic [1:0] dbg;
      logic [4:0] inv;

      dig_ct_driver #(.NUM_VEC(N), .MODE(MD), .SEED(SD)) u_dut (
         .CLK(CLK), .RST(RST), .START(START),
         .RSP1(r1), .RSP2(r2), .RSP3(r3),
         .IN1(i1), .IN2(i2), .IN3(i3), .IN4(i4), .IN5(i5),
         .BUSY(busy), .DONE(done), .ERR_CNT(err), .FIRST_ERR_VEC(first),
         .dbg_state(dbg)
      );

      assign inv        = {i5, i4, i3, i2, i1};
      assign busy_a[g]  = busy;
      assign done_a[g]  = done;
      assign err_a[g]   = err;
      assign first_a[g] = first;
      assign in_a[g]    = inv;

      // Cell under test: registered golden function plus an injected fault
      always @(posedge CLK) begin
         case (fault_mode)
            1:       {r1, r2, r3} <= golden(inv) | 3'b010;
            2:       {r1, r2, r3} <= golden(inv) ^ 3'b100;
            3:       {r1, r2, r3} <= golden(inv) ^ {($urandom_range(0, 5) == 0),
                                                    ($urandom_range(0, 5) == 0),
                                                    ($urandom_range(0, 5) == 0)};
            default: {r1, r2, r3} <= golden(inv);
         endcase
      end

      // Reference: mk = edges since the accepted START edge
      int         mk     = 0;
      bit         mrun   = 1'b0;
      int         merr   = 0;
      logic [4:0] mfirst = 5'd0;
      bit         mseen  = 1'b0;

      always @(posedge CLK or negedge RST) begin
         if (!RST) begin
            mrun <= 1'b0; mk <= 0; merr <= 0; mfirst <= 5'd0; mseen <= 1'b0;
         end else if ((!mrun || mk > N) && START) begin
            mrun <= 1'b1; mk <= 0; merr <= 0; mfirst <= 5'd0; mseen <= 1'b0;
         end else if (mrun && mk <= N) begin
            mk <= mk + 1;
            if (mk >= 1 && {r1, r2, r3} != golden(vec_of(MD, SD, mk - 1))) begin
               if (merr < 255) merr <= merr + 1;
               if (!mseen) begin
                  mseen  <= 1'b1;
                  mfirst <= vec_of(MD, SD, mk - 1);
               end
            end
         end
      end

      always @(negedge CLK) begin
         check($sformatf("u%0d.busy k=%0d", g, mk), int'(busy), int'(mrun && mk <= N));
         check($sformatf("u%0d.done k=%0d", g, mk), int'(done), int'(mrun && mk > N));
         check($sformatf("u%0d.in k=%0d", g, mk), int'(inv),
               (mrun && mk < N) ? int'(vec_of(MD, SD, mk)) : 0);
         check($sformatf("u%0d.err_cnt k=%0d", g, mk), int'(err), merr);
         check($sformatf("u%0d.first_err k=%0d", g, mk), int'(first), int'(mfirst));
      end
   end

   task automatic pulse_start();
      @(posedge CLK); #2 START = 1'b1;
      @(posedge CLK); #2 START = 1'b0;
   endtask

   // Observe a run from the START edge; c = edges elapsed since that edge
   task automatic watch(input int repulse_at);
      bit all_done;
      all_done  = 1'b0;
      seen_mask = 32'd0;
      vec1_seen = 5'd0;
      for (int i = 0; i < 3; i++) begin
         done_at[i]  = -1;
         busy_cnt[i] = 0;
      end
      for (int c = 0; c < 400 && !all_done; c++) begin
         @(negedge CLK); #1;
         for (int i = 0; i < 3; i++) begin
            if (busy_a[i]) busy_cnt[i]++;
            if (done_a[i] && done_at[i] < 0) done_at[i] = c;
         end
         if (c < 31) seen_mask = seen_mask | (32'd1 << in_a[1]);
         if (c == 1) vec1_seen = in_a[1];
         START    = (c == repulse_at);
         all_done = done_a[0] && done_a[1] && done_a[2];
      end
      START = 1'b0;
      check("run_timeout", int'(all_done), 1);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      fault_mode = 0;
      START      = 1'b0;
      RST        = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_in", int'(in_a[0]), 0);
      check("reset_busy", int'(busy_a[0]), 0);
      check("reset_done", int'(done_a[0]), 0);
      check("reset_err", int'(err_a[0]), 0);
      @(negedge CLK); #1 RST = 1'b1;

      // Clean counter and LFSR runs
      pulse_start();
      watch(-1);
      check("t1_busy_cycles", busy_cnt[0], 33);
      check("t1_done_at", done_at[0], 33);
      check("t1_err", int'(err_a[0]), 0);
      check("t1_first", int'(first_a[0]), 0);
      check("t3_lfsr_cover", int'(seen_mask), 32'hFFFF_FFFE);
      check("t3_vec1", int'(vec1_seen), 5'b00010);
      check("t3_err", int'(err_a[1]), 0);
      check("t1_long_done_at", done_at[2], 301);

      // RSP2 stuck high
      fault_mode = 1;
      pulse_start();
      watch(-1);
      check("t2_err", int'(err_a[0]), 8);
      check("t2_first", int'(first_a[0]), 6);

      // Restart from DONE clears results on the START edge
      pulse_start();
      check("t6_done_clr", int'(done_a[0]), 0);
      check("t6_err_clr", int'(err_a[0]), 0);
      check("t6_first_clr", int'(first_a[0]), 0);
      check("t6_busy", int'(busy_a[0]), 1);
      watch(-1);
      check("t6_err", int'(err_a[0]), 8);
      check("t6_first", int'(first_a[0]), 6);

      // RSP1 inverted on every vector
      fault_mode = 2;
      pulse_start();
      watch(-1);
      check("t4_err_sat", int'(err_a[2]), 255);
      check("t4_first", int'(first_a[2]), 0);
      check("t4_done_at", done_at[2], 301);
      check("t4_err_short", int'(err_a[0]), 32);

      // START while busy is ignored
      fault_mode = 0;
      pulse_start();
      watch(5);
      check("t5_done_at", done_at[0], 33);
      check("t5_busy_cycles", busy_cnt[0], 33);

      // Reset mid-run aborts immediately
      fault_mode = 3;
      pulse_start();
      repeat (12) @(negedge CLK);
      #1 RST = 1'b0;
      #1;
      check("t5_rst_in", int'(in_a[0]), 0);
      check("t5_rst_busy", int'(busy_a[0]), 0);
      check("t5_rst_done", int'(done_a[0]), 0);
      check("t5_rst_err", int'(err_a[0]), 0);
      check("t5_rst_first", int'(first_a[0]), 0);
      @(negedge CLK); #1 RST = 1'b1;
      fault_mode = 0;
      pulse_start();
      watch(-1);
      check("t5_fresh_done_at", done_at[0], 33);
      check("t5_fresh_err", int'(err_a[0]), 0);

      // Random response faults, scored by the reference model
      fault_mode = 3;
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(0, 4)) @(posedge CLK);
         pulse_start();
         watch(int'($urandom_range(2, 20)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dig_ct_driver.md
Name: dig_ct_driver

Overview:
Self-checking stimulus driver for the 5-input / 3-output registered logic cell. It generates the IN1..IN5 vector stream, captures the cell's registered OUT1..OUT3 responses on RSP1..RSP3, and compares each response against an internal golden model with matched one-cycle latency. It reports a mismatch count and the first failing vector. It sits beside the cell in bring-up and self-test builds.

Parameters:
NUM_VEC, 32, number of vectors per run; legal range 1..1023.
MODE, 0, vector source: 0 = binary counter, 1 = 5-bit LFSR.
SEED, 5'b00001, LFSR seed; must be nonzero; ignored when MODE=0.

Ports:
CLK  input  1  single clock; all state updates on posedge.
RST  input  1  asynchronous, active-low reset.
START  input  1  run request; sampled on posedge.
RSP1  input  1  cell OUT1.
RSP2  input  1  cell OUT2.
RSP3  input  1  cell OUT3.
IN1..IN5  output  1 each  registered stimulus to the cell; vector bits {IN5,IN4,IN3,IN2,IN1}.
BUSY  output  1  run in progress.
DONE  output  1  run complete; held until the next accepted START.
ERR_CNT  output  8  saturating mismatch count.
FIRST_ERR_VEC  output  5  vector of the first mismatch; 0 if none.

Behaviour:
- Reset (RST=0, async): state IDLE; IN1..IN5=0, BUSY=0, DONE=0, ERR_CNT=0, FIRST_ERR_VEC=0; index, LFSR and check pipeline cleared. Reset mid-run aborts the run. No partial results survive reset.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE/DONE with START=1 at edge e:
  - Next state DRIVE; BUSY=1, DONE=0.
  - ERR_CNT, FIRST_ERR_VEC and error-seen flag cleared.
  - Vector 0 driven on IN.
- START while BUSY is ignored.
- Vector i is driven at edge e+i for i=0..NUM_VEC-1, using a 10-bit index.
  - MODE=0: vector = index[4:0], wrapping past 31.
  - MODE=1: vector 0 = SEED; next = {v[3:0], v[4]^v[2]} (x^5+x^3+1, period 31).
- Golden model on the driven vector:
  - G1 = ~(~(IN1|IN2)&IN3)
  - G2 = ~(IN2&IN3)
  - G3 = IN3|~IN4|IN5
- Check pipeline:
  - At the edge after a vector is driven, register {G1,G2,G3}, the vector, and a valid bit. The cell registers its outputs on the same edge.
  - At the following edge, if valid and {RSP1,RSP2,RSP3}!={G1,G2,G3}: ERR_CNT increments, saturating at 255.
  - On the first mismatch of a run, FIRST_ERR_VEC is loaded with that vector.
  - Vector i is therefore checked at edge e+i+2.
- At edge e+NUM_VEC: state DRAIN, IN returns to 0, no new valid entries.
- At edge e+NUM_VEC+1: the last check completes; state DONE, BUSY=0, DONE=1.
- Results are stable while DONE=1. START in DONE starts a new run on the same edge rules.
- RSP inputs are ignored when no valid entry is in the pipeline.
- ERR_CNT stays at 255 once reached. FIRST_ERR_VEC is not overwritten by later mismatches.

Test Plan:
1. MODE=0, NUM_VEC=32, correct cell connected; pulse START.
   -> BUSY high 33 cycles; DONE rises at START edge+33; ERR_CNT=0; FIRST_ERR_VEC=0; IN sequence 0..31.
2. MODE=0, NUM_VEC=32, RSP2 forced 1.
   -> ERR_CNT=8 (vectors 6,7,14,15,22,23,30,31); FIRST_ERR_VEC=5'd6.
3. MODE=1, SEED=1, NUM_VEC=31, correct cell.
   -> all 31 nonzero vectors appear exactly once; vector 1 = 5'b00010; ERR_CNT=0.
4. MODE=0, NUM_VEC=300, RSP1 forced inverted.
   -> ERR_CNT saturates at 255; FIRST_ERR_VEC=0; DONE at START edge+301.
5. START re-pulsed during DRIVE.
   -> ignored, run length unchanged.
   Then drop RST for 1 cycle mid-run.
   -> immediately IN=0, BUSY=0, DONE=0, ERR_CNT=0; a fresh START completes normally.
6. START re-pulsed while DONE=1 after test 2.
   -> DONE clears, ERR_CNT and FIRST_ERR_VEC cleared on the START edge; rerun reproduces ERR_CNT=8.
